hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline control for the 5-stage core; feeds stage-latch enables/flushes around the forwarding unit.
//  Forwarding never sources a load result from MEM, so a load-use pair needs stalls; this block inserts them.
//  Also freezes on dcache/icache miss, squashes on taken branch/jump, and latches halt.
//  Registered FSM (RUN, LU_STALL, HALTED) plus a stall down-counter; outputs are comb. from state + inputs.
// PARAMETERS
//  LOAD_USE_STALL  2  bubbles inserted per load-use hazard (min 1, max 3)
// PORTS
//  CLK                   in   1   core clock, rising edge
//  nRST                  in   1   async reset, active low
//  decode_instruction    in   32  instruction in ID
//  execute_reg_wr_addr   in   5   EX destination reg
//  execute_reg_wr_en     in   1   EX writes a reg
//  execute_mem_to_reg    in   1   EX is a load (LW/LL)
//  memory_dmem_req       in   1   MEM stage issues dREN or dWEN
//  dhit                  in   1   dcache done this cycle
//  ihit                  in   1   icache returns instruction this cycle
//  branch_taken          in   1   branch resolved taken in EX
//  jump                  in   1   J/JAL/JR resolved in EX
//  write_back_halt       in   1   HALT in WB
//  pc_en                 out  1   PC update
//  fetch_decode_en       out  1   IF/ID latch enable
//  fetch_decode_flush    out  1   IF/ID load NOP
//  decode_execute_en     out  1   ID/EX latch enable
//  decode_execute_flush  out  1   ID/EX load NOP
//  execute_memory_en     out  1   EX/MEM latch enable
//  memory_write_back_en  out  1   MEM/WB latch enable
//  halt                  out  1   core halted (sticky)
// BEHAVIOUR
//  Reset: state=RUN, cnt=0; outputs while nRST low: all *_en=0, *_flush=0, halt=0.
//  Source use: rs used unless op in {J,JAL,LUI}; rt used for RTYPE,BEQ,BNE,SW,SC; reg 0 never hazards.
//  lu_hit = execute_mem_to_reg & execute_reg_wr_en & addr!=0 & addr matches a used source.
//  Priority per cycle, highest first:
//   1 HALTED: all en=0, flush=0, halt=1; leave only via nRST.
//   2 write_back_halt: next=HALTED; this cycle all en=0.
//   3 dfreeze = memory_dmem_req & ~dhit: all en=0, no flush; state and cnt hold.
//   4 branch_taken|jump: pc_en=1, all latch en=1, fetch_decode_flush=1, decode_execute_flush=1;
//     next=RUN, cnt=0 (squashes a pending consumer).
//   5 lu_hit in RUN, or state==LU_STALL: pc_en=0, fetch_decode_en=0, decode_execute_en=1,
//     decode_execute_flush=1, downstream en=1. RUN+lu_hit: cnt<=LOAD_USE_STALL-1, next=LU_STALL
//     (RUN if LOAD_USE_STALL==1). LU_STALL: cnt decrements, next=RUN when cnt==0.
//   6 ~ihit: pc_en=0, fetch_decode_en=1, fetch_decode_flush=1, rest en=1.
//   7 else all en=1, flush=0.
//  Total bubbles per hazard = LOAD_USE_STALL, counted only on unfrozen cycles.
//  No re-detection in LU_STALL; a new lu_hit is checked only after returning to RUN.
//  Register file is write-before-read; consumer reads the load value in ID while load is in WB.
//  ~ihit during LU_STALL ignored (PC already held). Flush and en both high = latch captures NOP.
//  Reset mid-stall or mid-freeze: immediate return to reset values, cnt=0.
// TESTING
//  LW $2 in EX, ADDU uses $2 in ID -> 2 cycles pc_en=0, decode_execute_flush=1, then RUN.
//  Same with dhit=0 for 3 cycles during stall #1 -> all en=0 3 cycles, still 2 bubbles.
//  LW $0, or LW $5 with consumer using $6 -> no stall; J with LW $2 in EX -> no stall.
//  branch_taken during LU_STALL -> both flushes=1, pc_en=1, next RUN, cnt=0.
//  ihit=0 in RUN -> pc_en=0, fetch_decode_flush=1; dhit=0 same cycle -> all en=0 instead.
//  write_back_halt=1 -> halt=1 and all en=0 forever; nRST low mid-LU_STALL -> RUN, cnt=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: load-use stalls, cache-miss freezes,
// branch/jump squashes and sticky halt. State is registered; outputs are combinational.
module hazard_unit #(
    parameter int LOAD_USE_STALL = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] decode_instruction,
    input  logic [4:0]  execute_reg_wr_addr,
    input  logic        execute_reg_wr_en,
    input  logic        execute_mem_to_reg,
    input  logic        memory_dmem_req,
    input  logic        dhit,
    input  logic        ihit,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        write_back_halt,
    output logic        pc_en,
    output logic        fetch_decode_en,
    output logic        fetch_decode_flush,
    output logic        decode_execute_en,
    output logic        decode_execute_flush,
    output logic        execute_memory_en,
    output logic        memory_write_back_en,
    output logic        halt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SC    = 6'h38;

    // cnt holds the bubbles still owed after the current one
    localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic        rs_used, rt_used;
    logic        lu_hit;
    logic        dfreeze;
    logic        unused_imm;

    assign opcode     = decode_instruction[31:26];
    assign rs         = decode_instruction[25:21];
    assign rt         = decode_instruction[20:16];
    assign unused_imm = ^decode_instruction[15:0];
    assign dfreeze    = memory_dmem_req & ~dhit;

    always_comb begin
        rs_used = !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI));
        rt_used = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                  (opcode == OP_SW)    || (opcode == OP_SC);
        lu_hit  = execute_mem_to_reg && execute_reg_wr_en && (execute_reg_wr_addr != 5'd0) &&
                  ((rs_used && (rs == execute_reg_wr_addr)) ||
                   (rt_used && (rt == execute_reg_wr_addr)));
    end

    always_comb begin
        pc_en                = 1'b1;
        fetch_decode_en      = 1'b1;
        fetch_decode_flush   = 1'b0;
        decode_execute_en    = 1'b1;
        decode_execute_flush = 1'b0;
        execute_memory_en    = 1'b1;
        memory_write_back_en = 1'b1;
        halt                 = 1'b0;
        state_d              = state_q;
        cnt_d                = cnt_q;

        if (state_q == HALTED) begin
            {pc_en, fetch_decode_en, decode_execute_en, execute_memory_en, memory_write_back_en} = '0;
            halt = 1'b1;
        end else if (write_back_halt) begin
            {pc_en, fetch_decode_en, decode_execute_en, execute_memory_en, memory_write_back_en} = '0;
            state_d = HALTED;
        end else if (dfreeze) begin
            {pc_en, fetch_decode_en, decode_execute_en, execute_memory_en, memory_write_back_en} = '0;
        end else if (branch_taken || jump) begin
            fetch_decode_flush   = 1'b1;
            decode_execute_flush = 1'b1;
            state_d              = RUN;
            cnt_d                = 2'd0;
        end else if ((state_q == LU_STALL) || lu_hit) begin
            // lu_hit is only honoured in RUN; LU_STALL never re-detects
            pc_en                = 1'b0;
            fetch_decode_en      = 1'b0;
            decode_execute_flush = 1'b1;
            if (state_q == RUN) begin
                cnt_d   = STALL_INIT;
                state_d = (LOAD_USE_STALL > 1) ? LU_STALL : RUN;
            end else if (cnt_q <= 2'd1) begin
                cnt_d   = 2'd0;
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (!ihit) begin
            pc_en              = 1'b0;
            fetch_decode_flush = 1'b1;
        end

        if (!nRST) begin
            {pc_en, fetch_decode_en, fetch_decode_flush, decode_execute_en,
             decode_execute_flush, execute_memory_en, memory_write_back_en, halt} = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
